// File: rtl/game_step_sequencer_if.sv
// Handshake bundle between the frame/step controller and the game datapath phases.
// The sequencer takes the slave view; whoever drives frame_start/restart/stall takes the master view.
interface game_step_sequencer_if;
    logic        frame_start;
    logic        restart;
    logic        stall;
    logic [11:0] phase_stb;
    logic [3:0]  phase_idx;
    logic        y_en;
    logic        render_en;
    logic        busy;
    logic        overrun;
    logic [15:0] frame_cnt;

    modport master (
        output frame_start, restart, stall,
        input  phase_stb, phase_idx, y_en, render_en, busy, overrun, frame_cnt
    );

    modport slave (
        input  frame_start, restart, stall,
        output phase_stb, phase_idx, y_en, render_en, busy, overrun, frame_cnt
    );
endinterface

// File: rtl/game_step_sequencer.sv
// Per-frame game step sequencer: after a start delay, each vblank pulse runs twelve
// one-hot phase strobes, with a vertical-update step once every Y_DIV steps.
module game_step_sequencer #(
    parameter int unsigned START_DELAY = 400000000,
    parameter int unsigned Y_DIV       = 6
) (
    input logic                  clk,
    input logic                  reset_n,
    game_step_sequencer_if.slave seq
);
    localparam int unsigned DIV_W     = (Y_DIV > 1) ? $clog2(Y_DIV) : 1;
    localparam int unsigned NUM_PHASE = 12;

    typedef enum logic [1:0] {
        ST_DELAY,
        ST_WAIT_FRAME,
        ST_RUN
    } state_t;

    state_t             state_reg,     state_next;
    logic [31:0]        delay_cnt_reg, delay_cnt_next;
    logic [DIV_W-1:0]   div_cnt_reg,   div_cnt_next;
    logic [11:0]        phase_stb_reg, phase_stb_next;
    logic [3:0]         phase_idx_reg, phase_idx_next;
    logic               y_en_reg,      y_en_next;
    logic               busy_reg,      busy_next;
    logic               overrun_reg,   overrun_next;
    logic               render_en_reg, render_en_next;
    logic [15:0]        frame_cnt_reg, frame_cnt_next;

    // Phase to strobe next: one past the last strobe, or the held phase after a stall.
    logic [3:0]  target_idx;
    logic [11:0] target_onehot;

    assign target_idx = (phase_stb_reg != 12'd0) ? phase_idx_reg + 4'd1 : phase_idx_reg;

    generate
        for (genvar gi = 0; gi < NUM_PHASE; gi++) begin : g_decode
            assign target_onehot[gi] = (target_idx == 4'(gi));
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        delay_cnt_next = delay_cnt_reg;
        div_cnt_next   = div_cnt_reg;
        phase_stb_next = 12'd0;
        phase_idx_next = phase_idx_reg;
        y_en_next      = y_en_reg;
        busy_next      = busy_reg;
        overrun_next   = overrun_reg;
        render_en_next = render_en_reg;
        frame_cnt_next = frame_cnt_reg;

        case (state_reg)
            ST_DELAY: begin
                delay_cnt_next = delay_cnt_reg + 32'd1;
                if (delay_cnt_reg == 32'(START_DELAY - 1)) begin
                    state_next     = ST_WAIT_FRAME;
                    delay_cnt_next = 32'd0;
                end
            end
            ST_WAIT_FRAME: begin
                // stall is deliberately ignored here so a step can never be lost.
                if (seq.frame_start) begin
                    state_next     = ST_RUN;
                    phase_stb_next = 12'h001;
                    phase_idx_next = 4'd0;
                    busy_next      = 1'b1;
                    render_en_next = 1'b0;
                    frame_cnt_next = frame_cnt_reg + 16'd1;
                    if (div_cnt_reg == DIV_W'(Y_DIV - 1)) begin
                        y_en_next    = 1'b1;
                        div_cnt_next = '0;
                    end else begin
                        y_en_next    = 1'b0;
                        div_cnt_next = div_cnt_reg + DIV_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (seq.frame_start) begin
                    overrun_next = 1'b1;
                end
                if (phase_stb_reg[NUM_PHASE-1]) begin
                    state_next     = ST_WAIT_FRAME;
                    phase_idx_next = 4'd0;
                    busy_next      = 1'b0;
                    render_en_next = 1'b1;
                end else begin
                    phase_idx_next = target_idx;
                    if (!seq.stall) begin
                        phase_stb_next = target_onehot;
                    end
                end
            end
            default: begin
                state_next = ST_DELAY;
            end
        endcase

        if (seq.restart) begin
            state_next     = ST_DELAY;
            delay_cnt_next = 32'd0;
            div_cnt_next   = '0;
            phase_stb_next = 12'd0;
            phase_idx_next = 4'd0;
            busy_next      = 1'b0;
            overrun_next   = 1'b0;
            render_en_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= ST_DELAY;
            delay_cnt_reg <= 32'd0;
            div_cnt_reg   <= '0;
            phase_stb_reg <= 12'd0;
            phase_idx_reg <= 4'd0;
            y_en_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            render_en_reg <= 1'b1;
            frame_cnt_reg <= 16'd0;
        end else begin
            state_reg     <= state_next;
            delay_cnt_reg <= delay_cnt_next;
            div_cnt_reg   <= div_cnt_next;
            phase_stb_reg <= phase_stb_next;
            phase_idx_reg <= phase_idx_next;
            y_en_reg      <= y_en_next;
            busy_reg      <= busy_next;
            overrun_reg   <= overrun_next;
            render_en_reg <= render_en_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    assign seq.phase_stb = phase_stb_reg;
    assign seq.phase_idx = phase_idx_reg;
    assign seq.y_en      = y_en_reg;
    assign seq.busy      = busy_reg;
    assign seq.overrun   = overrun_reg;
    assign seq.render_en = render_en_reg;
    assign seq.frame_cnt = frame_cnt_reg;
endmodule

// File: tb/tb_game_step_sequencer.sv
// Directed bench for game_step_sequencer: a step-level reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_game_step_sequencer;
    localparam int unsigned START_DELAY = 10;
    localparam int unsigned Y_DIV       = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    game_step_sequencer_if seq();

    game_step_sequencer #(
        .START_DELAY(START_DELAY),
        .Y_DIV      (Y_DIV)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .seq    (seq)
    );

    always #5 clk = ~clk;

    // Reference model: delay countdown, then steps of twelve phases consuming extra cycles on stall.
    bit          m_valid = 1'b0;
    int          m_delay_left;
    bit          m_stepping;
    int          m_next;
    int          m_steps;
    logic [11:0] m_stb;
    logic [3:0]  m_idx;
    logic        m_y, m_render, m_busy, m_ovr;
    logic [15:0] m_fcnt;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_valid = 1'b1; m_delay_left = START_DELAY; m_stepping = 1'b0; m_next = 0; m_steps = 0;
            m_stb = '0; m_idx = '0; m_y = 1'b0; m_render = 1'b1; m_busy = 1'b0; m_ovr = 1'b0; m_fcnt = '0;
        end else if (seq.restart) begin
            m_delay_left = START_DELAY; m_stepping = 1'b0; m_steps = 0;
            m_stb = '0; m_idx = '0; m_busy = 1'b0; m_ovr = 1'b0; m_render = 1'b1;
        end else if (m_delay_left > 0) begin
            m_delay_left--;
        end else if (!m_stepping) begin
            if (seq.frame_start) begin
                m_stepping = 1'b1; m_steps++; m_y = (m_steps % Y_DIV == 0);
                m_fcnt++; m_stb = 12'h001; m_idx = 4'd0; m_next = 1; m_busy = 1'b1; m_render = 1'b0;
            end
        end else begin
            if (seq.frame_start) m_ovr = 1'b1;
            if (m_next == 12) begin
                m_stepping = 1'b0; m_stb = '0; m_idx = '0; m_busy = 1'b0; m_render = 1'b1;
            end else if (seq.stall) begin
                m_stb = '0; m_idx = 4'(m_next);
            end else begin
                m_stb = 12'(1 << m_next); m_idx = 4'(m_next); m_next++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            vectors++;
            if ({seq.phase_stb, seq.phase_idx, seq.y_en, seq.render_en, seq.busy, seq.overrun, seq.frame_cnt} !==
                {m_stb, m_idx, m_y, m_render, m_busy, m_ovr, m_fcnt}) begin
                miscompares++;
                $display("FAIL cycle t=%0t: got stb=%03h idx=%0d y=%0b ren=%0b busy=%0b ovr=%0b fcnt=%0d, expected stb=%03h idx=%0d y=%0b ren=%0b busy=%0b ovr=%0b fcnt=%0d",
                         $time, seq.phase_stb, seq.phase_idx, seq.y_en, seq.render_en, seq.busy, seq.overrun, seq.frame_cnt,
                         m_stb, m_idx, m_y, m_render, m_busy, m_ovr, m_fcnt);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_frame();
        seq.frame_start = 1'b1;
        @(negedge clk);
        seq.frame_start = 1'b0;
    endtask

    task automatic walk_phases(input int from);
        for (int k = from; k < 12; k++) begin
            check("phase_stb", 32'(seq.phase_stb), 32'(1 << k));
            @(negedge clk);
        end
        check("busy_after_step", 32'(seq.busy), 32'd0);
    endtask

    task automatic plain_step(input int num, input logic exp_y);
        pulse_frame();
        check("y_en", 32'(seq.y_en), 32'(exp_y));
        walk_phases(0);
        $display("step %0d: y_en=%0b frame_cnt=%0d", num, seq.y_en, seq.frame_cnt);
    endtask

    initial begin
        seq.frame_start = 1'b0;
        seq.restart     = 1'b0;
        seq.stall       = 1'b0;

        // Reset values, then frame_start inside the delay window is ignored.
        tick(3);
        check("reset_busy", 32'(seq.busy), 32'd0);
        check("reset_render", 32'(seq.render_en), 32'd1);
        check("reset_stb", 32'(seq.phase_stb), 32'd0);
        check("reset_fcnt", 32'(seq.frame_cnt), 32'd0);
        reset_n = 1'b1;
        tick(5);
        pulse_frame();
        check("delay_stb", 32'(seq.phase_stb), 32'd0);
        check("delay_ovr", 32'(seq.overrun), 32'd0);
        tick(3);
        pulse_frame();
        check("delay_last_busy", 32'(seq.busy), 32'd0);

        // Step 1: first accepted frame_start at cycle 10.
        pulse_frame();
        check("start_busy", 32'(seq.busy), 32'd1);
        check("start_render", 32'(seq.render_en), 32'd0);
        check("start_fcnt", 32'(seq.frame_cnt), 32'd1);
        check("start_idx", 32'(seq.phase_idx), 32'd0);
        check("y_en", 32'(seq.y_en), 32'd0);
        walk_phases(0);
        check("end_render", 32'(seq.render_en), 32'd1);
        $display("step 1: y_en=%0b frame_cnt=%0d", seq.y_en, seq.frame_cnt);

        // Step 2: three stall cycles while phase 4 is pending.
        pulse_frame();
        check("y_en", 32'(seq.y_en), 32'd0);
        tick(3);
        check("pre_stall_stb", 32'(seq.phase_stb), 32'h008);
        seq.stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick(1);
            check("stall_stb", 32'(seq.phase_stb), 32'd0);
            check("stall_idx", 32'(seq.phase_idx), 32'd4);
        end
        seq.stall = 1'b0;
        tick(1);
        walk_phases(4);
        $display("step 2: y_en=%0b frame_cnt=%0d (stalled)", seq.y_en, seq.frame_cnt);

        plain_step(3, 1'b1);

        // Step 4 starts with stall high in the same cycle as frame_start.
        seq.stall = 1'b1;
        pulse_frame();
        seq.stall = 1'b0;
        check("stall_start_stb", 32'(seq.phase_stb), 32'h001);
        check("y_en", 32'(seq.y_en), 32'd0);
        walk_phases(0);
        $display("step 4: y_en=%0b frame_cnt=%0d", seq.y_en, seq.frame_cnt);

        plain_step(5, 1'b0);
        plain_step(6, 1'b1);
        check("fcnt_6", 32'(seq.frame_cnt), 32'd6);

        // Step 7: frame_start during phase 7 -> sticky overrun, step unaffected.
        pulse_frame();
        tick(7);
        check("phase7_stb", 32'(seq.phase_stb), 32'h080);
        pulse_frame();
        check("ovr_set", 32'(seq.overrun), 32'd1);
        check("ovr_stb", 32'(seq.phase_stb), 32'h100);
        tick(4);
        check("ovr_end_busy", 32'(seq.busy), 32'd0);
        tick(5);
        check("ovr_no_extra", 32'(seq.frame_cnt), 32'd7);
        check("ovr_sticky", 32'(seq.overrun), 32'd1);
        $display("step 7: overrun=%0b frame_cnt=%0d", seq.overrun, seq.frame_cnt);

        // Step 8: restart during phase 5, with a competing frame_start.
        pulse_frame();
        tick(5);
        check("phase5_stb", 32'(seq.phase_stb), 32'h020);
        seq.restart = 1'b1;
        seq.frame_start = 1'b1;
        tick(1);
        seq.restart = 1'b0;
        seq.frame_start = 1'b0;
        check("rst_stb", 32'(seq.phase_stb), 32'd0);
        check("rst_ovr", 32'(seq.overrun), 32'd0);
        check("rst_fcnt", 32'(seq.frame_cnt), 32'd8);
        check("rst_render", 32'(seq.render_en), 32'd1);
        tick(9);
        pulse_frame();
        check("redelay_busy", 32'(seq.busy), 32'd0);
        pulse_frame();
        check("restart_step_busy", 32'(seq.busy), 32'd1);
        check("restart_step_fcnt", 32'(seq.frame_cnt), 32'd9);
        check("restart_step_y", 32'(seq.y_en), 32'd0);
        $display("step 9: started after restart, frame_cnt=%0d", seq.frame_cnt);

        // Reset mid-step, asserted together with restart.
        tick(3);
        reset_n = 1'b0;
        seq.restart = 1'b1;
        tick(1);
        check("midrst_stb", 32'(seq.phase_stb), 32'd0);
        check("midrst_fcnt", 32'(seq.frame_cnt), 32'd0);
        check("midrst_busy", 32'(seq.busy), 32'd0);
        seq.restart = 1'b0;
        tick(1);
        reset_n = 1'b1;

        // frame_start on the last strobe cycle still counts as an overrun.
        tick(10);
        pulse_frame();
        tick(11);
        check("last_stb", 32'(seq.phase_stb), 32'h800);
        pulse_frame();
        check("last_ovr", 32'(seq.overrun), 32'd1);
        check("last_busy", 32'(seq.busy), 32'd0);
        tick(4);
        check("last_no_extra", 32'(seq.frame_cnt), 32'd1);
        $display("step 1 after reset: overrun=%0b frame_cnt=%0d", seq.overrun, seq.frame_cnt);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/game_step_sequencer.md
GAME_STEP_SEQUENCER -- requirements
Module: game_step_sequencer

Interface
REQ-001 SHALL have parameter START_DELAY, default 400000000; the number of cycles after reset or restart before the first step may run.
REQ-002 SHALL have parameter Y_DIV, default 6; vertical/gravity phases are enabled on one step in every Y_DIV steps.
REQ-003 SHALL use clk, input, 1 bit, as the system clock; all state updates on its rising edge.
REQ-004 SHALL use reset_n, input, 1 bit, as a synchronous, active-low reset.
REQ-005 SHALL have frame_start, input, 1 bit: a single-cycle pulse at vblank start from the VGA sync generator.
REQ-006 SHALL have restart, input, 1 bit: a synchronous request to return to the start delay.
REQ-007 SHALL have stall, input, 1 bit: holds the current phase while high.
REQ-008 SHALL have phase_stb, output, 12 bits: a one-hot single-cycle strobe per phase; 0 VEL_X, 1 VEL_Y, 2 BALL_VEL, 3 POS_X, 4 POS_Y, 5 BALL_POS, 6 FIX_X, 7 FIX_Y, 8 CALC0, 9 CALC1, 10 CALC2, 11 DETECT.
REQ-009 SHALL have phase_idx, output, 4 bits: the index of the current or next phase.
REQ-010 SHALL have y_en, output, 1 bit: high for the whole step when the step is a vertical-update step.
REQ-011 SHALL have render_en, output, 1 bit: high when the pixel address/RGB pipeline may update.
REQ-012 SHALL have busy, output, 1 bit: high while a step is in progress.
REQ-013 SHALL have overrun, output, 1 bit: a sticky flag set when a frame_start pulse is missed.
REQ-014 SHALL have frame_cnt, output, 16 bits: the number of steps started.

Function
REQ-015 SHALL implement states DELAY, WAIT_FRAME and RUN; all outputs registered.
REQ-016 SHALL, in DELAY, increment a 32-bit delay counter every cycle; at count START_DELAY-1 go to WAIT_FRAME next cycle; frame_start ignored and not counted as overrun.
REQ-017 SHALL, in WAIT_FRAME, on frame_start at cycle n, enter RUN at n+1 with phase_idx=0, busy=1, render_en=0, and frame_cnt incremented (0xFFFF wraps to 0).
REQ-018 SHALL, at each step start, set y_en=1 when div_cnt==Y_DIV-1 and wrap div_cnt to 0; otherwise set y_en=0 and increment div_cnt; y_en holds until the next step start.
REQ-019 SHALL, in RUN with stall=0, drive phase_stb[phase_idx]=1 for one cycle and advance phase_idx.
REQ-020 SHALL, in RUN with stall=1, drive phase_stb=0 and hold phase_idx; no phase is skipped or repeated.
REQ-021 SHALL, in the cycle after phase 11 is strobed, return to WAIT_FRAME with phase_idx=0, busy=0 and render_en=1; the unstalled step is therefore strobes at n+1..n+12 and idle at n+13.
REQ-022 SHALL, on frame_start during RUN (including the last strobe cycle), set overrun=1; the pulse is not queued and the step is not restarted.
REQ-023 SHALL, on frame_start during WAIT_FRAME in the same cycle as stall=1, still start the step; stall affects only RUN.
REQ-024 SHALL, on restart=1 in any state, enter DELAY next cycle and clear the delay counter, div_cnt, phase_idx, phase_stb, busy and overrun; frame_cnt is kept and render_en=1.
REQ-025 SHALL give restart priority over frame_start and stall; a step aborted mid-RUN emits no further strobes.
REQ-026 SHALL hold phase_stb=0 outside RUN; at most one bit is set in any cycle.

Reset
REQ-027 SHALL, on reset_n=0 at a clock edge, set state=DELAY, delay counter=0, div_cnt=0, phase_stb=0, phase_idx=0, y_en=0, busy=0, overrun=0, frame_cnt=0 and render_en=1; reset overrides restart.
REQ-028 SHALL, on reset asserted mid-RUN, emit no strobe in the following cycle.

Verification (START_DELAY=10, Y_DIV=3)
REQ-029 SHALL test: release reset, frame_start at cycle 5 -> no strobe and overrun=0; WAIT_FRAME reached by cycle 11.
REQ-030 SHALL test: frame_start at cycle n in WAIT_FRAME -> phase_stb = 0x001, 0x002, …, 0x800 on cycles n+1..n+12; busy=0 at n+13; frame_cnt=1.
REQ-031 SHALL test: stall high for 3 cycles while phase_idx=4 -> phase_stb=0 for 3 cycles, then 0x010; the step ends at n+15.
REQ-032 SHALL test: 6 consecutive steps -> y_en pattern 0,0,1,0,0,1.
REQ-033 SHALL test: frame_start during phase 7 -> overrun=1 and stays 1; the step completes unchanged and no extra step starts.
REQ-034 SHALL test: restart during phase 5 -> phase_stb=0 from the next cycle, state DELAY, overrun=0, frame_cnt unchanged; the next step waits 10 cycles plus frame_start.
